seq_pattern_detector: RTL
=========================

// Module: seq_pattern_detector
// PURPOSE
//  Serial bit-pattern detector: samples x each enabled clock, tracks longest matched prefix of
//  a LEN-bit pattern, flags y while a full match is held. Successor of the fixed 1110 FSM:
//  pattern width, reset pattern, overlap mode and counter width are parameters; pattern is
//  runtime-loadable; matches are counted. Sits between a serial front-end and control logic.
// PARAMETERS
//  LEN      4         pattern length in bits, >= 2
//  PATTERN  4'b1110   pattern loaded at reset; bit LEN-1 is the first bit received
//  OVERLAP  1         1: match tail seeds the next match; 0: after a match restart from empty
//  COUNT_W  8         width of the saturating match counter
// PORTS
//  clock        in   1            rising-edge clock, single domain
//  reset        in   1            synchronous, active-high
//  en           in   1            sample x this cycle; 0 = hold everything
//  x            in   1            serial data bit
//  load         in   1            1-cycle strobe: take pattern_in as new pattern
//  pattern_in   in   LEN          new pattern, bit LEN-1 first
//  y            out  1            1 while matched length == LEN (Moore decode of state)
//  match_len    out  clog2(LEN+1) current matched-prefix length 0..LEN
//  match_count  out  COUNT_W      number of completed matches, saturating
// BEHAVIOUR
//  - Reset (sync, highest priority): pattern<=PATTERN, state<=0, history<=0, match_count<=0;
//    hence y=0, match_len=0 in the cycle after the reset edge.
//  - State = matched length s in 0..LEN; history = last LEN sampled bits, newest in bit 0.
//  - en=1, load=0: h' = {history[LEN-2:0], x}. If OVERLAP=0 and s==LEN, treat valid bits as 1
//    (only x); else valid bits = min(s+1, LEN). next s = largest k <= valid with
//    h'[k-1:0] == pattern[LEN-1 -: k]; 0 if none. Full failure-function semantics: e.g.
//    1110 with 1111 then 0 reaches 4.
//  - y = (s == LEN): asserted the cycle after the final pattern bit is sampled; held while
//    en=0; latency 1 clock from last bit.
//  - match_count increments on every enabled edge where next s == LEN; saturates at all-ones,
//    never wraps. A held match (en=0) does not re-count.
//  - load=1 (any en): pattern<=pattern_in, s<=0, history<=0; x that cycle is discarded; count
//    kept. Match completes against the old pattern only if load is not asserted that edge.
//  - en=0, load=0: all registers hold.
//  - Reset during a partial or complete match: match discarded, not counted.
//  - Arithmetic: match_len and counter unsigned; no internal X propagation after reset.
// STRUCTURE
//  - Package seq_det_pkg: function prefix_len(hist, pat, valid) returning longest matching
//    prefix; localparam for match_len width (clog2(LEN+1)).
//  - One sub-module seq_det_next_state: combinational (history, x, pattern, s) -> next s;
//    top holds pattern/history/state/counter registers and y decode.
// TESTING
//  - Defaults, reset then x=1,1,1,0 with en=1 -> y=1 and match_count=1 one cycle after 4th bit.
//  - Defaults, x=1,1,1,1,0 -> match_len 1,2,3,3,4; y=1 after 5th bit; count=1.
//  - LEN=4 PATTERN=1010 OVERLAP=1, x=1,0,1,0,1,0 -> y high after bits 4 and 6; count=2.
//  - Same with OVERLAP=0 -> y high after bit 4 only; after bit 6 match_len=2; count=1.
//  - load pattern_in=0110 mid-sequence (state 3) -> match_len=0 next cycle; 0,1,1,0 -> y=1.
//  - COUNT_W=2, five matches -> match_count 1,2,3,3,3; reset mid-match -> y=0, count=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: width helpers and the
// longest-matching-prefix search used by the next-state logic.
package seq_det_pkg;

  // Upper bound on pattern length supported by the prefix search.
  localparam int unsigned MaxLen  = 32;
  localparam int unsigned MaxIdxW = 5;

  // Default pattern length and the matching match_len width.
  localparam int unsigned DefLen  = 4;
  localparam int unsigned DefLenW = $clog2(DefLen + 1);

  // Width needed to hold a matched length 0..len.
  function automatic int unsigned len_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

  // Largest k <= min(valid, len) with hist[k-1:0] == pat[len-1 -: k]; 0 if none.
  // hist holds newest bit in bit 0; pat holds its first bit in bit len-1.
  function automatic int prefix_len(input logic [MaxLen-1:0] hist,
                                    input logic [MaxLen-1:0] pat,
                                    input int len,
                                    input int valid);
    int best;
    logic ok;
    logic [MaxIdxW-1:0] hi;
    logic [MaxIdxW-1:0] pi;
    best = 0;
    for (int k = 1; k <= MaxLen; k++) begin
      if (k <= valid && k <= len) begin
        ok = 1'b1;
        for (int i = 0; i < MaxLen; i++) begin
          if (i < k) begin
            hi = MaxIdxW'(i);
            pi = MaxIdxW'(len - k + i);
            if (hist[hi] != pat[pi]) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_det_next_state.sv
// Combinational next matched-length computation for the pattern detector.
module seq_det_next_state
  import seq_det_pkg::*;
#(
  parameter int unsigned LEN     = 4,
  parameter bit          OVERLAP = 1'b1,
  parameter int unsigned LW      = $clog2(LEN + 1)
) (
  input  logic [LEN-1:0] i_history,
  input  logic           i_x,
  input  logic [LEN-1:0] i_pattern,
  input  logic [LW-1:0]  i_state,
  output logic [LW-1:0]  o_next_state
);

  localparam logic [LW-1:0] LenVal = LW'(LEN);

  logic [LEN-1:0]    w_hist_next;
  logic [MaxLen-1:0] w_hist_pad;
  logic [MaxLen-1:0] w_pat_pad;
  int                w_valid;

  assign w_hist_next = {i_history[LEN-2:0], i_x};

  // Bound the search by how many history bits can belong to the current attempt.
  always_comb begin
    w_hist_pad = '0;
    w_pat_pad  = '0;
    w_hist_pad[LEN-1:0] = w_hist_next;
    w_pat_pad[LEN-1:0]  = i_pattern;
    if (!OVERLAP && i_state == LenVal) begin
      w_valid = 1;  // non-overlapping: only the new bit may start a match
    end else if (i_state == LenVal) begin
      w_valid = int'(LEN);
    end else begin
      w_valid = int'(i_state) + 1;
    end
    o_next_state = LW'(prefix_len(w_hist_pad, w_pat_pad, int'(LEN), w_valid));
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with runtime-loadable pattern and saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned      LEN     = 4,
  parameter logic [LEN-1:0]   PATTERN = LEN'(4'b1110),
  parameter bit               OVERLAP = 1'b1,
  parameter int unsigned      COUNT_W = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_en,
  input  logic                       i_x,
  input  logic                       i_load,
  input  logic [LEN-1:0]             i_pattern_in,
  output logic                       o_y,
  output logic [$clog2(LEN+1)-1:0]   o_match_len,
  output logic [COUNT_W-1:0]         o_match_count
);

  localparam int unsigned   LW     = $clog2(LEN + 1);
  localparam logic [LW-1:0] LenVal = LW'(LEN);

  logic [LEN-1:0]     r_pattern;
  logic [LEN-1:0]     r_history;
  logic [LW-1:0]      r_state;
  logic [COUNT_W-1:0] r_count;
  logic               r_y;
  logic [LW-1:0]      w_next_state;

  seq_det_next_state #(
    .LEN     (LEN),
    .OVERLAP (OVERLAP),
    .LW      (LW)
  ) u_next_state (
    .i_history    (r_history),
    .i_x          (i_x),
    .i_pattern    (r_pattern),
    .i_state      (r_state),
    .o_next_state (w_next_state)
  );

  // Register update: reset beats load, load beats sampling; en=0 holds everything.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pattern <= PATTERN;
      r_history <= '0;
      r_state   <= '0;
      r_count   <= '0;
      r_y       <= 1'b0;
    end else if (i_load) begin
      r_pattern <= i_pattern_in;
      r_history <= '0;
      r_state   <= '0;
      r_y       <= 1'b0;
    end else if (i_en) begin
      r_history <= {r_history[LEN-2:0], i_x};
      r_state   <= w_next_state;
      r_y       <= (w_next_state == LenVal);
      if (w_next_state == LenVal && r_count != {COUNT_W{1'b1}}) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_y           = r_y;
  assign o_match_len   = r_state;
  assign o_match_count = r_count;

endmodule
